// File: rtl/tim_cmp_sched.sv
// tim_cmp_sched: multi-channel compare scheduler for the 64-bit system timer.
// A single 64-bit unsigned >= comparator is shared round-robin among NUM_CH
// channels. Each channel can be one-shot or periodic (auto-reload) and has a
// sticky pending bit that feeds the interrupt status and the timer interrupt.
module tim_cmp_sched #(
   parameter int NUM_CH = 4,
   parameter int CH_W   = 2
) (
   input  logic              i_sys_clk,
   input  logic              i_sys_rst,
   input  logic [63:0]       i_cnt_val,
   input  logic              i_cfg_wr_en,
   input  logic [CH_W-1:0]   i_cfg_ch,
   input  logic [63:0]       i_cfg_cmp,
   input  logic [63:0]       i_cfg_period,
   input  logic              i_cfg_periodic,
   input  logic [NUM_CH-1:0] i_ch_en,
   input  logic [NUM_CH-1:0] i_int_en,
   input  logic [NUM_CH-1:0] i_pend_clr,
   output logic [NUM_CH-1:0] o_int_status,
   output logic              o_tim_int,
   output logic [CH_W-1:0]   o_cur_ch
);

   // Per-channel configuration and state
   logic [63:0]       r_cmp      [NUM_CH];
   logic [63:0]       r_period   [NUM_CH];
   logic [NUM_CH-1:0] r_periodic;
   logic [NUM_CH-1:0] r_armed;
   logic [NUM_CH-1:0] r_int_status;
   logic [CH_W-1:0]   r_cur_ch;

   // Next-state values
   logic [63:0]       w_cmp_nxt      [NUM_CH];
   logic [63:0]       w_period_nxt   [NUM_CH];
   logic [NUM_CH-1:0] w_periodic_nxt;
   logic [NUM_CH-1:0] w_armed_nxt;
   logic [NUM_CH-1:0] w_int_status_nxt;

   // Shared comparator path for the channel in the current slot
   logic [63:0]       w_cur_cmp;
   logic [63:0]       w_cur_period;
   logic              w_cur_reload;
   logic              w_hit;
   logic [64:0]       w_reload_sum;
   logic [NUM_CH-1:0] w_cfg_sel;
   logic [NUM_CH-1:0] w_slot_sel;

   // Select the current slot's channel and evaluate its hit and reload sum
   always_comb begin
      w_cur_cmp    = r_cmp[r_cur_ch];
      w_cur_period = r_period[r_cur_ch];
      w_hit        = r_armed[r_cur_ch] & i_ch_en[r_cur_ch] & (i_cnt_val >= w_cur_cmp);
      // 65-bit sum: the carry out marks a reload that would wrap past 2^64-1
      w_reload_sum = {1'b0, w_cur_cmp} + {1'b0, w_cur_period};
      w_cur_reload = r_periodic[r_cur_ch] & (w_cur_period != 64'd0);
   end

   // Decode which channel is being configured and which one owns the slot
   always_comb begin
      w_cfg_sel  = '0;
      w_slot_sel = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         w_cfg_sel[k]  = i_cfg_wr_en & (i_cfg_ch == CH_W'(k));
         w_slot_sel[k] = (r_cur_ch == CH_W'(k));
      end
   end

   // Per-channel next state: cfg write beats a hit; pend_clr beats a status set
   always_comb begin
      w_periodic_nxt   = r_periodic;
      w_armed_nxt      = r_armed;
      w_int_status_nxt = r_int_status;
      for (int k = 0; k < NUM_CH; k++) begin
         w_cmp_nxt[k]    = r_cmp[k];
         w_period_nxt[k] = r_period[k];

         if (w_cfg_sel[k]) begin
            // A new configuration always re-arms and discards a same-cycle hit
            w_cmp_nxt[k]      = i_cfg_cmp;
            w_period_nxt[k]   = i_cfg_period;
            w_periodic_nxt[k] = i_cfg_periodic;
            w_armed_nxt[k]    = 1'b1;
         end else if (w_hit && w_slot_sel[k]) begin
            if (w_cur_reload) begin
               // Advance the compare point; disarm on overflow instead of wrapping
               w_cmp_nxt[k]   = w_reload_sum[63:0];
               w_armed_nxt[k] = ~w_reload_sum[64];
            end else begin
               w_armed_nxt[k] = 1'b0;
            end
         end else begin
            w_armed_nxt[k] = r_armed[k];
         end

         if (i_pend_clr[k]) begin
            w_int_status_nxt[k] = 1'b0;
         end else if (w_hit && w_slot_sel[k] && !w_cfg_sel[k]) begin
            w_int_status_nxt[k] = 1'b1;
         end else begin
            w_int_status_nxt[k] = r_int_status[k];
         end
      end
   end

   // Register channel state and advance the round-robin slot pointer
   always_ff @(posedge i_sys_clk) begin
      if (i_sys_rst) begin
         for (int k = 0; k < NUM_CH; k++) begin
            r_cmp[k]    <= 64'd0;
            r_period[k] <= 64'd0;
         end
         r_periodic   <= '0;
         r_armed      <= '0;
         r_int_status <= '0;
         r_cur_ch     <= '0;
      end else begin
         for (int k = 0; k < NUM_CH; k++) begin
            r_cmp[k]    <= w_cmp_nxt[k];
            r_period[k] <= w_period_nxt[k];
         end
         r_periodic   <= w_periodic_nxt;
         r_armed      <= w_armed_nxt;
         r_int_status <= w_int_status_nxt;
         // NUM_CH is a power of two, so natural wrap gives NUM_CH-1 -> 0
         r_cur_ch     <= r_cur_ch + CH_W'(1);
      end
   end

   assign o_int_status = r_int_status;
   assign o_cur_ch     = r_cur_ch;
   // Interrupt line follows int_en immediately; status itself is never masked
   assign o_tim_int    = |(r_int_status & i_int_en);

endmodule

// File: tb/tb_tim_cmp_sched.sv
// Self-checking bench for tim_cmp_sched: directed scenarios followed by a
// randomized phase, all compared every cycle against a behavioural model.
module tb_tim_cmp_sched;
   localparam int NCH = 4;
   localparam int CW  = 2;

   logic           clk = 1'b0;
   logic           rst = 1'b0;
   logic [63:0]    cnt = 64'd0;
   logic           cfg_wr_en = 1'b0;
   logic [CW-1:0]  cfg_ch = '0;
   logic [63:0]    cfg_cmp = 64'd0;
   logic [63:0]    cfg_period = 64'd0;
   logic           cfg_periodic = 1'b0;
   logic [NCH-1:0] ch_en = '0;
   logic [NCH-1:0] int_en = '0;
   logic [NCH-1:0] pend_clr = '0;
   logic [NCH-1:0] o_int_status;
   logic           o_tim_int;
   logic [CW-1:0]  o_cur_ch;

   int checks = 0;
   int errors = 0;

   // Behavioural model state
   logic [63:0]    m_cmp [NCH];
   logic [63:0]    m_per [NCH];
   logic [NCH-1:0] m_pdc = '0;
   logic [NCH-1:0] m_arm = '0;
   logic [NCH-1:0] m_st  = '0;
   int             m_slot = 0;

   tim_cmp_sched #(.NUM_CH(NCH), .CH_W(CW)) dut (
      .i_sys_clk(clk), .i_sys_rst(rst), .i_cnt_val(cnt),
      .i_cfg_wr_en(cfg_wr_en), .i_cfg_ch(cfg_ch), .i_cfg_cmp(cfg_cmp),
      .i_cfg_period(cfg_period), .i_cfg_periodic(cfg_periodic),
      .i_ch_en(ch_en), .i_int_en(int_en), .i_pend_clr(pend_clr),
      .o_int_status(o_int_status), .o_tim_int(o_tim_int), .o_cur_ch(o_cur_ch)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock: predict from the rules, clock the DUT, compare, drop strobes
   task automatic step();
      logic [63:0]    n_cmp [NCH];
      logic [63:0]    n_per [NCH];
      logic [NCH-1:0] n_pdc, n_arm, n_st;
      int             n_slot, s, c;
      logic           hit;
      for (int k = 0; k < NCH; k++) begin
         n_cmp[k] = m_cmp[k];
         n_per[k] = m_per[k];
      end
      n_pdc = m_pdc; n_arm = m_arm; n_st = m_st;
      s = m_slot;
      if (rst) begin
         for (int k = 0; k < NCH; k++) begin
            n_cmp[k] = 64'd0;
            n_per[k] = 64'd0;
         end
         n_pdc = '0; n_arm = '0; n_st = '0;
         n_slot = 0;
      end else begin
         c = int'(cfg_ch);
         hit = m_arm[s] && ch_en[s] && (cnt >= m_cmp[s]);
         if (cfg_wr_en) begin
            n_cmp[c] = cfg_cmp;
            n_per[c] = cfg_period;
            n_pdc[c] = cfg_periodic;
            n_arm[c] = 1'b1;
         end
         if (hit && !(cfg_wr_en && c == s)) begin
            n_st[s] = 1'b1;
            if (m_pdc[s] && m_per[s] != 64'd0) begin
               n_cmp[s] = m_cmp[s] + m_per[s];
               // overflow of cmp + period beyond 2^64-1
               if (m_per[s] > ~m_cmp[s]) n_arm[s] = 1'b0;
            end else begin
               n_arm[s] = 1'b0;
            end
         end
         n_st = n_st & ~pend_clr;
         n_slot = (s + 1) % NCH;
      end
      @(posedge clk);
      #1;
      for (int k = 0; k < NCH; k++) begin
         m_cmp[k] = n_cmp[k];
         m_per[k] = n_per[k];
      end
      m_pdc = n_pdc; m_arm = n_arm; m_st = n_st; m_slot = n_slot;
      chk("int_status", 64'(o_int_status), 64'(m_st));
      chk("cur_ch", 64'(o_cur_ch), 64'(m_slot));
      chk("tim_int", 64'(o_tim_int), 64'(|(m_st & int_en)));
      cfg_wr_en = 1'b0;
      pend_clr  = '0;
   endtask

   task automatic cfg(input int ch, input logic [63:0] cmpv, input logic [63:0] per, input logic pdc);
      cfg_wr_en    = 1'b1;
      cfg_ch       = CW'(ch);
      cfg_cmp      = cmpv;
      cfg_period   = per;
      cfg_periodic = pdc;
      step();
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   initial begin
      int rise_cnt;
      int rises;
      logic prev;
      for (int k = 0; k < NCH; k++) begin
         m_cmp[k] = 64'd0;
         m_per[k] = 64'd0;
      end

      // Reset
      rst = 1'b1;
      run(2);
      chk("rst_status", 64'(o_int_status), 64'd0);
      chk("rst_cur_ch", 64'(o_cur_ch), 64'd0);
      chk("rst_tim_int", 64'(o_tim_int), 64'd0);
      rst = 1'b0;

      // One-shot on ch1 at 100
      ch_en = 4'b1111; int_en = 4'b0010; cnt = 64'd90;
      cfg(1, 64'd100, 64'd0, 1'b0);
      rise_cnt = 0;
      for (int v = 90; v <= 110; v++) begin
         cnt = 64'(v);
         step();
         if (o_int_status[1] === 1'b1 && rise_cnt == 0) rise_cnt = v;
      end
      chk("t1_latency_ok", 64'(rise_cnt >= 100 && rise_cnt <= 103), 64'd1);
      chk("t1_status1", 64'(o_int_status[1]), 64'd1);
      chk("t1_tim_int", 64'(o_tim_int), 64'd1);
      pend_clr[1] = 1'b1;
      step();
      for (int v = 111; v <= 121; v++) begin cnt = 64'(v); step(); end
      chk("t1_no_refire", 64'(o_int_status[1]), 64'd0);

      // Periodic ch2: 50, +20
      cnt = 64'd40;
      cfg(2, 64'd50, 64'd20, 1'b1);
      rises = 0; prev = 1'b0;
      for (int v = 40; v <= 105; v++) begin
         cnt = 64'(v);
         if (m_st[2]) pend_clr[2] = 1'b1;
         step();
         if (o_int_status[2] === 1'b1 && !prev) rises++;
         prev = o_int_status[2];
      end
      chk("t2_three_hits", 64'(rises), 64'd3);
      cnt = 64'd109;
      for (int i = 0; i < 8; i++) begin
         if (m_st[2]) pend_clr[2] = 1'b1;
         step();
         if (o_int_status[2] === 1'b1 && !prev) rises++;
         prev = o_int_status[2];
      end
      chk("t2_cmp_not_109", 64'(rises), 64'd3);
      cnt = 64'd110;
      for (int i = 0; i < 4; i++) begin
         step();
         if (o_int_status[2] === 1'b1 && !prev) rises++;
         prev = o_int_status[2];
      end
      chk("t2_cmp_110", 64'(rises), 64'd4);

      // Periodic ch0 near the top of the range: carry disarms
      ch_en = 4'b1011; int_en = 4'b1111;
      cnt = 64'hFFFF_FFFF_FFFF_FFFB;
      cfg(0, 64'hFFFF_FFFF_FFFF_FFF6, 64'd20, 1'b1);
      run(5);
      chk("t3_hit", 64'(o_int_status[0]), 64'd1);
      pend_clr[0] = 1'b1;
      step();
      cnt = 64'hFFFF_FFFF_FFFF_FFFF;
      run(8);
      for (int v = 0; v < 16; v++) begin cnt = 64'(v); step(); end
      chk("t3_disarmed", 64'(o_int_status[0]), 64'd0);

      // ch3: pend_clr in the hit cycle, then cfg write in the hit cycle
      cnt = 64'd150;
      cfg(3, 64'd200, 64'd0, 1'b0);
      while (m_slot != 3) step();
      cnt = 64'd300; pend_clr[3] = 1'b1;
      step();
      run(8);
      chk("t4_clr_wins", 64'(o_int_status[3]), 64'd0);
      cnt = 64'd100;
      cfg(3, 64'd250, 64'd0, 1'b0);
      while (m_slot != 3) step();
      cnt = 64'd300;
      cfg(3, 64'd1000, 64'd0, 1'b0);
      run(8);
      chk("t4_cfg_wins", 64'(o_int_status[3]), 64'd0);
      cnt = 64'd1000;
      run(4);
      chk("t4_new_cmp", 64'(o_int_status[3]), 64'd1);

      // ch_en gating on ch1
      ch_en = 4'b1001; cnt = 64'd600;
      cfg(1, 64'd500, 64'd0, 1'b0);
      run(20);
      chk("t5_gated", 64'(o_int_status[1]), 64'd0);
      ch_en = 4'b1011;
      run(4);
      chk("t5_reenabled", 64'(o_int_status[1]), 64'd1);

      // Reset mid-operation
      ch_en = 4'b1111;
      cfg(0, 64'd0, 64'd1, 1'b1);
      run(8);
      chk("t6_pre_status0", 64'(o_int_status[0]), 64'd1);
      rst = 1'b1;
      step();
      chk("t6_status", 64'(o_int_status), 64'd0);
      chk("t6_tim_int", 64'(o_tim_int), 64'd0);
      chk("t6_cur_ch", 64'(o_cur_ch), 64'd0);
      rst = 1'b0; cnt = 64'd5000;
      run(12);
      chk("t6_no_hits", 64'(o_int_status), 64'd0);

      // Randomized phase
      for (int i = 0; i < 1500; i++) begin
         rst = ($urandom_range(0, 199) == 0);
         if ($urandom_range(0, 6) == 0) begin
            cfg_wr_en    = 1'b1;
            cfg_ch       = CW'($urandom_range(0, NCH - 1));
            cfg_cmp      = cnt + 64'($urandom_range(0, 60));
            cfg_period   = ($urandom_range(0, 3) == 0) ? 64'd0 : 64'($urandom_range(1, 40));
            cfg_periodic = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 9) == 0) cfg_cmp = 64'hFFFF_FFFF_FFFF_FFC0 + 64'($urandom_range(0, 63));
         end
         ch_en    = NCH'($urandom) | NCH'($urandom);
         int_en   = NCH'($urandom);
         pend_clr = NCH'($urandom) & NCH'($urandom);
         if ($urandom_range(0, 99) == 0) cnt = 64'hFFFF_FFFF_FFFF_FF00;
         else cnt = cnt + 64'($urandom_range(0, 5));
         step();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
